// File: rtl/blink_sched_pkg.sv
// Shared types and helpers for the blink scheduler.
//   state_t     : scheduler FSM state (IDLE, ON, OFF, GAP)
//   DEF_*       : default widths for the phase timer and per-requester count
//   count_slice : pulls requester idx's count field out of the flattened
//                 req_count bus (bus must fit in MAX_FLAT_W, burst_w < 32)
package blink_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int DEF_CNT_W   = 25;
  localparam int DEF_BURST_W = 4;
  localparam int MAX_FLAT_W  = 256;

  function automatic logic [31:0] count_slice(input logic [MAX_FLAT_W-1:0] flat,
                                              input int idx,
                                              input int burst_w);
    logic [MAX_FLAT_W-1:0] shifted;
    logic [31:0]           mask;
    shifted = flat >> (idx * burst_w);
    mask    = (32'd1 << burst_w) - 32'd1;
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/blink_scheduler_if.sv
// Requester/LED-side bundle of the blink scheduler.
//   req         : per-requester level request
//   req_count   : per-requester blink count, slice i = [i*BURST_W +: BURST_W]
//   half_period : ON/OFF phase length in clk cycles (0 behaves as 1)
//   blink       : LED drive
//   grant       : one-hot owner of the running burst, zero when idle
//   done        : one-cycle completion pulse to the owner
//   busy        : scheduler is not idle
// Handshake: a requester raises req[i] (with its count valid) and holds it;
// the scheduler answers with grant[i] for the whole burst and then a single
// done[i] cycle. req[i] may drop at the done cycle; if still high there it is
// a fresh request. Dropping it earlier does not cancel the running burst.
// master = requester/test side, slave = scheduler side.
interface blink_scheduler_if
  import blink_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*BURST_W-1:0] req_count;
  logic [CNT_W-1:0]           half_period;
  logic                       blink;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;

  modport master (
    output req, req_count, half_period,
    input  blink, grant, done, busy
  );

  modport slave (
    input  req, req_count, half_period,
    output blink, grant, done, busy
  );

endinterface

// File: rtl/blink_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : index where the search begins (wraps modulo NUM_REQ)
//   enable : when low no grant is produced
//   gnt    : one-hot winner
//   idx    : encoded winner
//   found  : a winner exists
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr + k cannot overflow before the modulo fold.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (enable && !found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin blink scheduler: one LED shared between NUM_REQ requesters.
// A granted requester gets count blinks of half_period ON + half_period OFF,
// followed by GAP_TICKS idle cycles, then a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : blink_scheduler_if slave modport (parameters must match)
//   state_dbg  : current FSM state, for observation only
module blink_scheduler
  import blink_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_W   = DEF_BURST_W,
  parameter int GAP_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  blink_scheduler_if.slave    bus,
  output state_t              state_dbg
);

  localparam int               IDX_W  = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_TICKS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     half_m1_q, half_m1_d;
  logic [BURST_W-1:0]   remaining_q, remaining_d;
  logic                 blink_q, blink_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic [BURST_W-1:0]   win_count;
  logic [CNT_W-1:0]     hp_m1;
  logic                 timer_zero;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .enable (state_q == IDLE),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  assign win_count  = BURST_W'(count_slice(MAX_FLAT_W'(bus.req_count), int'(arb_idx), BURST_W));
  // A zero half_period behaves as one cycle per phase.
  assign hp_m1      = (bus.half_period == '0) ? '0 : bus.half_period - CNT_W'(1);
  assign timer_zero = (timer_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      timer_q     <= '0;
      half_m1_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      half_m1_q   <= half_m1_d;
      remaining_q <= remaining_d;
    end
  end

  // Next state. The timer is loaded with (phase length - 1) on entry and the
  // phase ends on the edge where it reads zero.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    half_m1_d   = half_m1_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          owner_d     = arb_idx;
          ptr_d       = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          half_m1_d   = hp_m1;
          remaining_d = win_count;
          if (win_count == '0) begin
            state_d = GAP;
            timer_d = GAP_M1;
          end else begin
            state_d = ON;
            timer_d = hp_m1;
          end
        end
      end
      ON: begin
        if (timer_zero) begin
          state_d = OFF;
          timer_d = half_m1_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      OFF: begin
        if (timer_zero) begin
          if (remaining_q > BURST_W'(1)) begin
            state_d     = ON;
            timer_d     = half_m1_q;
            remaining_d = remaining_q - BURST_W'(1);
          end else begin
            state_d = GAP;
            timer_d = GAP_M1;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (timer_zero) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, taken from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    blink_d = (state_d == ON);
    grant_d = (state_d == IDLE) ? '0 : (NUM_REQ'(1) << owner_d);
    done_d  = (state_q == GAP && state_d == IDLE) ? (NUM_REQ'(1) << owner_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      blink_q <= blink_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign bus.blink = blink_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_blink_scheduler.sv
module tb_blink_scheduler;
  import blink_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 25;
  localparam int BURST_W = 4;
  localparam int GAP     = 4;
  localparam int EW      = 32 + NUM_REQ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1);
  end

  blink_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();
  state_t state_dbg;

  blink_scheduler #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .BURST_W(BURST_W), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] grant_q[$];
  logic [EW-1:0] done_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  // ---------------- stimulus state ----------------
  logic [NUM_REQ-1:0] req_drv;
  logic [NUM_REQ-1:0] keep_mask;
  logic [BURST_W-1:0] cnt_drv[NUM_REQ];
  logic [CNT_W-1:0]   hp_drv;
  bit                 auto_mode;

  // ---------------- reference model ----------------
  // A burst decided in cycle t occupies cycles t+1 .. t+L, done in t+L+1,
  // L = 2*h*c + GAP (or GAP when c == 0).
  int m_ptr, m_free_at, last_t;
  bit b_valid;
  int b_s, b_l, b_h, b_c, b_owner;

  task automatic drive_bus();
    bus.req = req_drv;
    for (int i = 0; i < NUM_REQ; i++) bus.req_count[i*BURST_W +: BURST_W] = cnt_drv[i];
    bus.half_period = hp_drv;
  endtask

  task automatic model_reset();
    grant_q.delete();
    done_q.delete();
    b_valid   = 0;
    m_ptr     = 0;
    m_free_at = 0;
  endtask

  function automatic logic [BURST_W-1:0] rand_cnt();
    if ($urandom_range(0, 9) == 0) return BURST_W'(15);
    return BURST_W'($urandom_range(0, 3));
  endfunction

  task automatic tick();
    int t, o, w, c, h, l;
    logic [NUM_REQ-1:0] e_grant, e_done;
    logic e_blink, e_busy;
    bit own;
    @(negedge clk);
    t = cyc;
    last_t  = t;
    e_grant = '0;
    e_done  = '0;
    e_blink = 1'b0;
    e_busy  = 1'b0;
    if (b_valid) begin
      o = t - b_s;
      if (o >= 0 && o < b_l) begin
        e_busy  = 1'b1;
        e_grant = onehot(b_owner);
        if (b_c > 0 && o < 2*b_h*b_c && (o % (2*b_h)) < b_h) e_blink = 1'b1;
      end else if (o == b_l) begin
        e_done = onehot(b_owner);
      end
    end
    check("cycle_outputs", {bus.blink, bus.busy, bus.grant, bus.done},
          {e_blink, e_busy, e_grant, e_done});

    // requester behaviour for the coming edge
    for (int i = 0; i < NUM_REQ; i++) begin
      own = b_valid && b_owner == i && (t - b_s) < b_l;
      if (auto_mode) begin
        if (e_done[i]) begin
          if ($urandom_range(0, 2) != 0) req_drv[i] = 1'b0;
          else cnt_drv[i] = rand_cnt();
        end else if (own) begin
          if ($urandom_range(0, 29) == 0) req_drv[i] = 1'b0;
          if ($urandom_range(0, 9) == 0) cnt_drv[i] = rand_cnt();
        end else if (!req_drv[i] && $urandom_range(0, 7) == 0) begin
          req_drv[i] = 1'b1;
          cnt_drv[i] = rand_cnt();
        end
      end else if (e_done[i] && !keep_mask[i]) begin
        req_drv[i] = 1'b0;
      end
    end
    if (auto_mode && $urandom_range(0, 39) == 0) hp_drv = CNT_W'($urandom_range(0, 3));
    drive_bus();

    // arbitration the DUT performs at the next edge
    if (rst_n && t >= m_free_at && req_drv != '0) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req_drv[i]) w = i;
      end
      c = int'(cnt_drv[w]);
      h = (hp_drv == '0) ? 1 : int'(hp_drv);
      l = (c == 0) ? GAP : 2*h*c + GAP;
      b_valid = 1; b_s = t + 1; b_l = l; b_h = h; b_c = c; b_owner = w;
      m_free_at = t + 1 + l;
      m_ptr     = (w + 1) % NUM_REQ;
      grant_q.push_back({32'(t + 1), onehot(w)});
      done_q.push_back({32'(t + 1 + l), onehot(w)});
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while (!(req_drv == '0 && (!b_valid || last_t >= b_s + b_l)) && n < limit) begin
      tick();
      n++;
    end
    check("idle_reached", (n >= limit), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    req_drv = '0;
    drive_bus();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [NUM_REQ-1:0] prev_grant;
    logic [EW-1:0] e;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.grant != '0 && prev_grant == '0) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", {32'(cyc), bus.grant}, '0);
          end else begin
            e = grant_q.pop_front();
            check("grant_event", {32'(cyc), bus.grant}, e);
          end
        end
        if (bus.done != '0) begin
          if (done_q.size() == 0) begin
            check("done_unexpected", {32'(cyc), bus.done}, '0);
          end else begin
            e = done_q.pop_front();
            check("done_event", {32'(cyc), bus.done}, e);
          end
        end
      end
      prev_grant = bus.grant;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n     = 1'b0;
    req_drv   = '0;
    keep_mask = '0;
    hp_drv    = CNT_W'(3);
    auto_mode = 0;
    last_t    = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt_drv[i] = '0;
    model_reset();
    drive_bus();
    repeat (3) @(negedge clk);
    check("reset_blink", bus.blink, 1'b0);
    check("reset_grant", bus.grant, '0);
    check("reset_done",  bus.done,  '0);
    check("reset_busy",  bus.busy,  1'b0);
    check("reset_state", state_dbg, IDLE);
    rst_n = 1'b1;
    repeat (3) tick();

    // single request, count 2
    cnt_drv[0] = BURST_W'(2);
    req_drv    = 4'b0001;
    run_until_idle(200);

    // asynchronous reset in the middle of an ON phase
    cnt_drv[0] = BURST_W'(3);
    req_drv    = 4'b0001;
    repeat (3) tick();
    check("pre_reset_blink", bus.blink, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_blink", bus.blink, 1'b0);
    check("async_grant", bus.grant, '0);
    check("async_busy",  bus.busy,  1'b0);
    check("async_done",  bus.done,  '0);
    model_reset();
    req_drv = '0;
    drive_bus();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    // round robin, all requesting, count 1, re-requests held
    for (int i = 0; i < NUM_REQ; i++) cnt_drv[i] = BURST_W'(1);
    req_drv   = 4'b1111;
    keep_mask = 4'b1111;
    repeat (50) tick();
    keep_mask = '0;
    req_drv   = '0;
    run_until_idle(200);

    // count zero: gap only
    cnt_drv[2] = '0;
    req_drv    = 4'b0100;
    run_until_idle(100);

    // latching of half_period and count
    cnt_drv[0] = BURST_W'(2);
    hp_drv     = CNT_W'(3);
    req_drv    = 4'b0001;
    keep_mask  = 4'b0001;
    repeat (3) tick();
    hp_drv     = CNT_W'(7);
    cnt_drv[0] = BURST_W'(1);
    repeat (20) tick();
    keep_mask  = '0;
    run_until_idle(200);
    hp_drv     = '0;
    cnt_drv[1] = BURST_W'(2);
    req_drv    = 4'b0010;
    run_until_idle(100);
    hp_drv     = CNT_W'(3);

    // req drop mid-burst and owner re-request
    do_reset();
    cnt_drv[0] = BURST_W'(1);
    cnt_drv[1] = BURST_W'(1);
    req_drv    = 4'b0011;
    keep_mask  = 4'b0001;
    repeat (14) tick();
    req_drv[1] = 1'b0;
    keep_mask  = '0;
    run_until_idle(200);

    // randomized traffic
    auto_mode = 1;
    repeat (2500) tick();
    auto_mode = 0;
    keep_mask = '0;
    req_drv   = '0;
    run_until_idle(500);
    repeat (3) tick();

    check("grant_q_empty", grant_q.size(), 0);
    check("done_q_empty",  done_q.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
- Round-robin scheduler that shares one counter-driven blink output between NUM_REQ requesters.
- Each requester asks for a burst of N blinks. The scheduler grants one requester at a time and times ON/OFF phases with an internal down-counter.
- It inserts an inter-burst gap, then returns a one-cycle done pulse to the granted requester.
- Sits between status/event sources and the board LED pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 25, width of the phase timer and of half_period.
- BURST_W, 4, width of each requester's blink-count field.
- GAP_TICKS, 16, idle cycles inserted after every burst (>=1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_REQ  level request per requester; held until its done pulse.
- req_count  in  NUM_REQ*BURST_W  blink count per requester; slice i = bits [i*BURST_W +: BURST_W].
- half_period  in  CNT_W  ON-phase and OFF-phase length in clk cycles; sampled at grant.
- blink  out  1  LED drive, registered.
- grant  out  NUM_REQ  one-hot owner of the current burst, registered; all-zero when idle.
- done  out  NUM_REQ  one-cycle pulse to the owner when its burst completes.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - blink, grant, done and busy all 0.
  - Round-robin pointer=0; timer=0; blinks-remaining=0.
- States and transitions:
  - IDLE -> ON when any req bit is high. Same edge: grant the winner; latch its count and half_period (0 treated as 1); blink=1.
  - If the latched count is 0, IDLE -> GAP instead, with blink=0.
  - ON -> OFF after half_period cycles; blink=0.
  - OFF -> ON after half_period cycles while blinks-remaining > 1. Decrement blinks-remaining; blink=1.
  - OFF -> GAP after half_period cycles on the last blink.
  - GAP -> IDLE after GAP_TICKS cycles. Same edge: grant clears and done[owner] is set for exactly one cycle.
- Timer: loads phase length minus 1 on state entry; the state exits on the edge where timer==0.
- Arbitration:
  - Search starts at the pointer and wraps modulo NUM_REQ; the first asserted req wins.
  - On grant, pointer = winner+1 (mod NUM_REQ).
  - Arbitration happens only in IDLE. IDLE always lasts at least one cycle, so done and the next grant never coincide.
- Latched values:
  - req_count and half_period are sampled only at grant.
  - Changes mid-burst have no effect on the current burst.
- req drop: a req deasserted mid-burst does not abort the burst. The burst runs to completion and done still pulses.
- Owner re-request: the owner's req still high at done is treated as a new request. It loses to any other pending requester under round robin.
- Widths: the timer counts down in CNT_W bits. Counts up to 2^BURST_W-1 are supported with no wrap.
- blink is derived from state only (ON=1), so it is glitch-free.

Decomposition:
- Package blink_sched_pkg holds:
  - state enum {IDLE, ON, OFF, GAP}, 2 bits;
  - default CNT_W and BURST_W constants;
  - a function extracting slice i of req_count.
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: req, pointer, enable;
  - outputs: one-hot grant and encoded winner index;
  - purely combinational; the pointer register stays in blink_scheduler.

Test Plan (GAP_TICKS=4 override, half_period=3 unless noted):
- Reset mid-burst: assert rst_n=0 during ON -> blink, grant, busy and done all 0 immediately (asynchronous). After release, idle until a req arrives.
- Single request: req=0001, count0=2, req seen in IDLE at cycle 0. Required response:
  - blink=1 in cycles 1-3 and 7-9, 0 in cycles 4-6 and 10-16;
  - grant=0001 in cycles 1-16;
  - done[0]=1 only in cycle 17, with grant=0000.
- Round robin: req=1111, all counts=1 -> grant order 0001, 0010, 0100, 1000, 0001. Each burst lasts 10 busy cycles; at least one IDLE cycle between bursts.
- Count zero: req=0100, count2=0 -> no blink pulse; GAP for 4 cycles; done[2] pulses once.
- Latch check: half_period changed from 3 to 7 during a burst -> current phases remain 3 cycles; the next grant uses 7. half_period=0 -> phases of 1 cycle.
- Req drop and re-request:
  - Drop: req[1] deasserted during ON -> burst completes; done[1] pulses.
  - Re-request: req=0011 held, owner 0 -> next grant goes to 0010 (pointer advanced), not 0001.
